uart_tx_fifo_reader: RTL and testbench
======================================

Name: uart_tx_fifo_reader

Overview:
- Read-side consumer of the shared byte FIFO in the UART calculator datapath.
- Pops one byte at a time whenever the FIFO is non-empty and serialises it onto the UART TX line as 8N1, LSB first.
- Sits between the result FIFO and the top-level TX pin; it is the transmit end matching the receive/write path that fills the FIFO.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and UART data field.
- CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); legal range is 2 or more.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- FIFO_DATA_OUT  input  DATA_WIDTH  FIFO read data; registered, valid one cycle after the read strobe.
- FIFO_EMPTY  input  1  FIFO empty flag.
- WR_ACTIVE  input  1  writer owns the shared FIFO port this cycle; the reader must not strobe.
- FIFO_E  output  1  FIFO enable; 1-cycle pulse for a read.
- FIFO_R_WR  output  1  tied to 0 (read) whenever FIFO_E is high; 0 otherwise.
- TX  output  1  UART serial line; idle high.
- BUSY  output  1  high from FETCH through the end of STOP.
- TX_DONE  output  1  1-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE, TX=1, BUSY=0, TX_DONE=0, FIFO_E=0, FIFO_R_WR=0, bit counter=0, baud counter=0.
- Reset mid-frame aborts the frame immediately. TX returns to 1 on that edge. The byte in flight is lost and is not re-read.
- IDLE:
  - If !FIFO_EMPTY && !WR_ACTIVE, go to FETCH.
  - Otherwise stay in IDLE; WR_ACTIVE stalls the read.
- FETCH (1 cycle): FIFO_E=1, FIFO_R_WR=0, BUSY=1. Go to LOAD.
- LOAD (1 cycle):
  - FIFO_DATA_OUT is valid at the end of this cycle; capture it into shift_reg.
  - Clear the baud counter and go to START.
- START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - TX=shift_reg[0]; hold each bit for CLKS_PER_BIT cycles, then shift right.
  - After DATA_WIDTH bits, go to STOP (or PARITY when the optional feature is enabled).
- STOP:
  - TX=1 for CLKS_PER_BIT cycles; TX_DONE=1 on the final cycle.
  - Next state is IDLE. Back-to-back frames therefore have one idle cycle plus FETCH/LOAD (3 cycles) of TX=1 between stop and start.
- Latency: first start-bit cycle is 2 cycles after leaving IDLE.
- Frame length: (2+DATA_WIDTH)*CLKS_PER_BIT cycles of line time.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps; the bit advances on terminal count.
- FIFO_EMPTY and WR_ACTIVE are sampled only in IDLE and ignored while BUSY.
- FIFO_E is never asserted while FIFO_EMPTY=1 or WR_ACTIVE=1 at the deciding edge.
- TX is registered, with no combinational glitch path.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - TX = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, (3+DATA_WIDTH)*CLKS_PER_BIT cycles.
- Undefined: the PARITY state and XOR logic are absent; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - UART_IDLE_LVL=1'b1.
  - START_LVL=1'b0.
  - STOP_LVL=1'b1.
- Sub-module uart_baud_tick: parameter CLKS_PER_BIT; ports CLK, RST, CLR, TICK. Emits TICK on terminal count and restarts on CLR.
- FSM, shift register and bit counter stay in the top module.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
- Reset while FIFO_EMPTY=1 for 20 cycles -> TX=1, BUSY=0, FIFO_E never asserted.
- Single byte: FIFO holds 0xA5, EMPTY=0 then 1 after the pop.
  - Exactly one FIFO_E pulse, with FIFO_R_WR=0.
  - TX sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; TX_DONE pulses at cycle 40 of the frame.
- Back-to-back 0x00 then 0xFF with EMPTY=0 throughout:
  - Two FIFO_E pulses, two frames.
  - 3 cycles of TX=1 between the first stop bit and the second start bit.
- WR_ACTIVE=1 for 5 cycles while EMPTY=0 -> no FIFO_E until WR_ACTIVE drops; FETCH occurs the cycle after.
- RST pulsed during the 4th data bit of 0x3C -> TX=1 and BUSY=0 on the next edge; no TX_DONE; next frame starts cleanly.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit=1; TX_DONE at cycle 44 of the frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART calculator transmit path.
// PARITY is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam logic START_LVL     = 1'b0;
    localparam logic STOP_LVL      = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises TICK (registered)
// during the terminal-count cycle; CLR restarts the count from zero.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (CLR || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        // Registered compare on the next count so TICK lines up with cnt_q == LAST.
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Pops bytes from the shared result FIFO and serialises them as 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA_OUT,
    input  logic                  FIFO_EMPTY,
    input  logic                  WR_ACTIVE,
    output logic                  FIFO_E,
    output logic                  FIFO_R_WR,
    output logic                  TX,
    output logic                  BUSY,
    output logic                  TX_DONE
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  fifo_e_q, fifo_e_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic baud_clr;
    logic baud_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK (CLK),
        .RST (RST),
        .CLR (baud_clr),
        .TICK(baud_tick)
    );

    // Timer is held at zero until the frame starts, so START gets a full bit.
    assign baud_clr = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        fifo_e_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (!FIFO_EMPTY && !WR_ACTIVE) begin
                    state_d  = FETCH;
                    fifo_e_d = 1'b1;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d   = FIFO_DATA_OUT;
                bit_cnt_d = '0;
                tx_d      = START_LVL;
                state_d   = START;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^FIFO_DATA_OUT;
`endif
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = STOP_LVL;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = STOP_LVL;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LVL;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LVL;
            busy_q    <= 1'b0;
            fifo_e_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            fifo_e_q  <= fifo_e_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign TX        = tx_q;
    assign BUSY      = busy_q;
    assign FIFO_E    = fifo_e_q;
    assign FIFO_R_WR = 1'b0;
    // Both terms are flops: the terminal-count cycle of the stop bit.
    assign TX_DONE   = (state_q == STOP) && baud_tick;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader with CLKS_PER_BIT=4 and a small FIFO model.
// Covers the parity frame when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_reader;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_active = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_e, fifo_r_wr, tx, busy, tx_done;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;

    logic [7:0] mem [0:15];
    int wr_n = 0;
    int rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_n);

    always #5 clk = ~clk;

    // Registered-read FIFO: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_e && !fifo_r_wr) begin
            fifo_dout <= mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_e) fe_count++;
    end

    uart_tx_fifo_reader #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .FIFO_DATA_OUT(fifo_dout),
        .FIFO_EMPTY   (fifo_empty),
        .WR_ACTIVE    (wr_active),
        .FIFO_E       (fifo_e),
        .FIFO_R_WR    (fifo_r_wr),
        .TX           (tx),
        .BUSY         (busy),
        .TX_DONE      (tx_done)
    );

    task automatic push(input logic [7:0] b);
        mem[wr_n[3:0]] = b;
        wr_n = wr_n + 1;
    endtask

    // Waits for the start bit, checks idle cycles before it, then the whole frame.
    task automatic check_frame(input logic [7:0] b, input int exp_gap, input string tag);
        logic [NBITS-1:0] fr;
        int gap;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        fr[9] = ^b;
`endif
        fr[NBITS-1] = 1'b1;
        gap = 0;
        @(negedge clk);
        while (tx === 1'b1 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        checks++;
        if (gap !== exp_gap) begin
            errors++;
            $display("FAIL %s gap: got %0d idle cycles, expected %0d", tag, gap, exp_gap);
        end
        for (int c = 1; c <= NBITS * CPB; c++) begin
            checks++;
            if (tx !== fr[(c-1)/CPB] || tx_done !== (c == NBITS * CPB) || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s cycle %0d: tx=%b done=%b busy=%b, expected tx=%b done=%b busy=1",
                         tag, c, tx, tx_done, busy, fr[(c-1)/CPB], (c == NBITS * CPB));
            end
            if (c < NBITS * CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_e !== 1'b0 || fifo_r_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b fe=%b rw=%b, expected 1 0 0 0 0",
                     tx, busy, tx_done, fifo_e, fifo_r_wr);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_e !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle cycle %0d: tx=%b busy=%b fe=%b, expected 1 0 0", i, tx, busy, fifo_e);
            end
        end
    endtask

    task automatic test_single_byte();
        int fe0 = fe_count;
        push(8'hA5);
        @(negedge clk);
        checks++;
        if (fifo_e !== 1'b1 || fifo_r_wr !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_fetch: fe=%b rw=%b busy=%b tx=%b, expected 1 0 1 1", fifo_e, fifo_r_wr, busy, tx);
        end
        @(negedge clk);
        checks++;
        if (fifo_e !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_load: fe=%b busy=%b tx=%b, expected 0 1 1", fifo_e, busy, tx);
        end
        check_frame(8'hA5, 0, "single_A5");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL single_after: busy=%b tx=%b done=%b, expected 0 1 0", busy, tx, tx_done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fe_count - fe0 !== 1) begin
            errors++;
            $display("FAIL single_pops: got %0d strobes, expected 1", fe_count - fe0);
        end
    endtask

    task automatic test_back_to_back();
        int fe0 = fe_count;
        push(8'h00);
        push(8'hFF);
        check_frame(8'h00, 2, "b2b_00");
        check_frame(8'hFF, 3, "b2b_FF");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after: busy=%b tx=%b, expected 0 1", busy, tx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fe_count - fe0 !== 2) begin
            errors++;
            $display("FAIL b2b_pops: got %0d strobes, expected 2", fe_count - fe0);
        end
    endtask

    task automatic test_wr_active();
        wr_active = 1'b1;
        push(8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_e !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL wr_stall cycle %0d: fe=%b busy=%b, expected 0 0", i, fifo_e, busy);
            end
        end
        wr_active = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_e !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_release_fetch: fe=%b busy=%b, expected 1 1", fifo_e, busy);
        end
        @(negedge clk);
        check_frame(8'h5A, 0, "wr_5A");
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int fe0 = fe_count;
        logic bad;
        push(8'h3C);
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 18; c++) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit3: tx=%b busy=%b, expected 1 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_e !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b done=%b fe=%b, expected 1 0 0 0", tx, busy, tx_done, fifo_e);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b0 || fifo_e !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || fe_count - fe0 !== 1) begin
            errors++;
            $display("FAIL post_reset_quiet: activity=%b strobes=%0d, expected 0 and 1", bad, fe_count - fe0);
        end
        push(8'h81);
        @(negedge clk);
        checks++;
        if (fifo_e !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: fe=%b, expected 1", fifo_e);
        end
        @(negedge clk);
        check_frame(8'h81, 0, "restart_81");
        @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        push(8'h07);
        check_frame(8'h07, 2, "parity_07");
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_wr_active();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
